// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared sizes, FSM state type and rotating-priority search
//                for the decoded round-robin arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package arb_pkg;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } state_t;

    // First requester found when searching ptr, ptr+1, ... (mod N_REQ).
    // Scanning from the far end lets the nearest hit overwrite later ones.
    function automatic logic [ADDR_W-1:0] rr_pick(
        input logic [N_REQ-1:0]  req,
        input logic [ADDR_W-1:0] ptr
    );
        logic [ADDR_W-1:0] idx;
        logic [ADDR_W-1:0] win;
        win = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + ADDR_W'(i);
            if (req[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dec2to4_en.sv
`default_nettype none
// ============================================================================
//  Module      : dec2to4_en
//  Description : Combinational 2-to-4 decoder with enable; Y[i] = E & (A==i).
//  Revision    : 1.0  initial release
// ============================================================================
module dec2to4_en (
    input  logic       E,
    input  logic [1:0] A,
    output logic [3:0] Y
);

    for (genvar i = 0; i < 4; i++) begin : g_dec
        assign Y[i] = E & (A == 2'(i));
    end

endmodule
`default_nettype wire

// File: rtl/dec_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dec_rr_arbiter
//  Description : Four-way round-robin arbiter with hold limit; the one-hot
//                grant is produced by decoding the registered grant index.
//  Revision    : 1.0  initial release
// ============================================================================
module dec_rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic [ADDR_W-1:0] gnt_addr,
    output logic              gnt_valid,
    output logic              busy
);

    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

    state_t            r_state,     w_state;
    logic [ADDR_W-1:0] r_ptr,       w_ptr;
    logic [7:0]        r_hold_cnt,  w_hold_cnt;
    logic [ADDR_W-1:0] r_gnt_addr,  w_gnt_addr;
    logic              r_gnt_valid, w_gnt_valid;

    logic [ADDR_W-1:0] w_win;
    logic [7:0]        w_hold_inc;
    logic              w_release;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
            r_gnt_addr  <= '0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_ptr       <= w_ptr;
            r_hold_cnt  <= w_hold_cnt;
            r_gnt_addr  <= w_gnt_addr;
            r_gnt_valid <= w_gnt_valid;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_ptr       = r_ptr;
        w_hold_cnt  = r_hold_cnt;
        w_gnt_addr  = r_gnt_addr;
        w_gnt_valid = r_gnt_valid;

        w_win      = rr_pick(req, r_ptr);
        w_hold_inc = (r_hold_cnt == 8'hFF) ? r_hold_cnt : r_hold_cnt + 8'd1;
        // A dropped request and an expired hold on the same edge still
        // produce one release and one pointer step.
        w_release  = !req[r_gnt_addr] ||
                     ((c_max_hold != 8'd0) && (r_hold_cnt == c_max_hold));

        case (r_state)
            IDLE, RELEASE: begin
                if (|req) begin
                    w_state     = GRANT;
                    w_gnt_addr  = w_win;
                    w_gnt_valid = 1'b1;
                    w_hold_cnt  = 8'd1;
                end else begin
                    w_state     = IDLE;
                    w_gnt_valid = 1'b0;
                end
            end
            GRANT: begin
                w_hold_cnt = w_hold_inc;
                if (w_release) begin
                    w_state     = RELEASE;
                    w_gnt_valid = 1'b0;
                    w_ptr       = r_gnt_addr + ADDR_W'(1);
                end
            end
            default: begin
                w_state     = IDLE;
                w_gnt_valid = 1'b0;
            end
        endcase
    end

    dec2to4_en u_dec (
        .E (r_gnt_valid),
        .A (r_gnt_addr),
        .Y (gnt)
    );

    assign gnt_addr  = r_gnt_addr;
    assign gnt_valid = r_gnt_valid;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dec_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dec_rr_arbiter
//  Description : Scoreboard bench for dec_rr_arbiter (MAX_HOLD 8 and 3).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dec_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_a, req_b;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] addr_a, addr_b;
    logic       valid_a, valid_b, busy_a, busy_b;
    int         sel;
    int         n_chk = 0;
    int         n_fail = 0;

    typedef struct {
        int         dut;
        logic [3:0] gnt;
        logic [1:0] addr;
        logic       busy;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    dec_rr_arbiter #(.MAX_HOLD(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a),
        .gnt_addr(addr_a), .gnt_valid(valid_a), .busy(busy_a)
    );

    dec_rr_arbiter #(.MAX_HOLD(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b),
        .gnt_addr(addr_b), .gnt_valid(valid_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_outputs(input int dut, input string tag, input logic [3:0] eg,
                               input logic [1:0] ea, input logic eb);
        logic [3:0] g;
        logic [1:0] a;
        logic       v, b;
        g = (dut == 1) ? gnt_b   : gnt_a;
        a = (dut == 1) ? addr_b  : addr_a;
        v = (dut == 1) ? valid_b : valid_a;
        b = (dut == 1) ? busy_b  : busy_a;
        chk({tag, ".gnt"},   8'(g), 8'(eg));
        chk({tag, ".addr"},  8'(a), 8'(ea));
        chk({tag, ".valid"}, 8'(v), 8'(eg != 4'b0000));
        chk({tag, ".busy"},  8'(b), 8'(eb));
    endtask

    // Drive one request pattern, queue what must appear after the next edge.
    task automatic cyc(input string tag, input logic [3:0] r, input logic [3:0] eg,
                       input logic [1:0] ea, input logic eb);
        exp_t e;
        @(negedge clk);
        if (sel == 1) req_b = r;
        else          req_a = r;
        e.dut = sel; e.gnt = eg; e.addr = ea; e.busy = eb;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            chk_outputs(e.dut, tag, e.gnt, e.addr, e.busy);
        end
    endtask

    task automatic async_reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        #1 chk_outputs(sel, tag, 4'b0000, 2'd0, 1'b0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel   = 0;
        rst_n = 1'b0;
        req_a = 4'b1111;
        req_b = 4'b0000;

        // reset held with all requests high
        repeat (2) @(posedge clk);
        #1;
        chk_outputs(0, "rst_a", 4'b0000, 2'd0, 1'b0);
        chk_outputs(1, "rst_b", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        cyc("rst_exit", 4'b1111, 4'b0001, 2'd0, 1'b1);
        cyc("rst_rel",  4'b0000, 4'b0000, 2'd0, 1'b1);
        cyc("rst_idle", 4'b0000, 4'b0000, 2'd0, 1'b0);

        // single requester held for five cycles
        for (int i = 0; i < 5; i++) cyc("single", 4'b0100, 4'b0100, 2'd2, 1'b1);
        cyc("single_rel",  4'b0000, 4'b0000, 2'd2, 1'b1);
        cyc("single_idle", 4'b0000, 4'b0000, 2'd2, 1'b0);

        // pointer now 3: search 3 then 0
        cyc("wrap",      4'b0101, 4'b0001, 2'd0, 1'b1);
        cyc("wrap_rel",  4'b0000, 4'b0000, 2'd0, 1'b1);
        cyc("wrap_idle", 4'b0000, 4'b0000, 2'd0, 1'b0);

        // fairness from ptr=0, each winner drops after two cycles
        async_reset_pulse("rst_pulse");
        for (int k = 0; k < 4; k++) begin
            logic [3:0] oh;
            oh = 4'b0001 << k;
            cyc("rr_g0", 4'b1111,  oh,      2'(k), 1'b1);
            cyc("rr_g1", 4'b1111,  oh,      2'(k), 1'b1);
            cyc("rr_gap", ~oh,     4'b0000, 2'(k), 1'b1);
        end
        cyc("rr_wrap", 4'b1111, 4'b0001, 2'd0, 1'b1);
        cyc("rr_rel",  4'b0000, 4'b0000, 2'd0, 1'b1);
        cyc("rr_idle", 4'b0000, 4'b0000, 2'd0, 1'b0);

        // hold limit of 3 with two persistent requesters
        sel = 1;
        for (int i = 0; i < 3; i++) cyc("hold_0", 4'b0011, 4'b0001, 2'd0, 1'b1);
        cyc("hold_gap0", 4'b0011, 4'b0000, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) cyc("hold_1", 4'b0011, 4'b0010, 2'd1, 1'b1);
        cyc("hold_gap1", 4'b0011, 4'b0000, 2'd1, 1'b1);
        cyc("hold_back", 4'b0011, 4'b0001, 2'd0, 1'b1);
        cyc("hold_rel",  4'b0000, 4'b0000, 2'd0, 1'b1);
        cyc("hold_idle", 4'b0000, 4'b0000, 2'd0, 1'b0);

        // limit reached on the same edge the request drops: ptr moves once
        cyc("sim_g",    4'b0011, 4'b0010, 2'd1, 1'b1);
        cyc("sim_g",    4'b0011, 4'b0010, 2'd1, 1'b1);
        cyc("sim_g",    4'b0011, 4'b0010, 2'd1, 1'b1);
        cyc("sim_rel",  4'b0001, 4'b0000, 2'd1, 1'b1);
        cyc("sim_next", 4'b0101, 4'b0100, 2'd2, 1'b1);
        cyc("sim_rel2", 4'b0000, 4'b0000, 2'd2, 1'b1);
        cyc("sim_idle", 4'b0000, 4'b0000, 2'd2, 1'b0);

        // asynchronous reset in the middle of a grant to requester 3
        sel = 0;
        cyc("mid_g", 4'b1000, 4'b1000, 2'd3, 1'b1);
        cyc("mid_g", 4'b1000, 4'b1000, 2'd3, 1'b1);
        async_reset_pulse("mid_rst");
        cyc("mid_regrant", 4'b1000, 4'b1000, 2'd3, 1'b1);
        cyc("mid_rel",     4'b0000, 4'b0000, 2'd3, 1'b1);
        cyc("mid_idle",    4'b0000, 4'b0000, 2'd3, 1'b0);

        // reset clears ptr: after a release of 1 (ptr=2), reset, then 0 beats 2
        cyc("ptr_g",   4'b0010, 4'b0010, 2'd1, 1'b1);
        cyc("ptr_rel", 4'b0000, 4'b0000, 2'd1, 1'b1);
        async_reset_pulse("ptr_rst");
        cyc("ptr_zero", 4'b0101, 4'b0001, 2'd0, 1'b1);

        chk("sb_drained", 8'(sb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
